wb_regfile_dual: RTL and testbench
==================================

// Module: wb_regfile_dual
// PURPOSE
// - Write-back end of the dual-issue MEM/WB pipeline registers: consumes both lanes' registered
//   MemToReg/RegWrite/mem_read_data/alu_result/write_reg and commits results to the architectural
//   register file.
// - Selects write-back data per lane, writes up to 2 regs/cycle, serves 4 read ports to ID with
//   same-cycle write->read bypass, and keeps a retired-write counter.
// PARAMETERS
// - DATA_W  32  register/data width
// - ADDR_W  5   register index width (2**ADDR_W registers)
// - BYPASS  1   1: read ports forward same-cycle write data; 0: read ports return stored value only
// PORTS
// - clk              in   1       clock; all state updates on posedge
// - reset            in   1       synchronous, active-high reset
// - MemToReg0/1      in   1       lane0/lane1 select: 1 = mem_read_data, 0 = alu_result
// - RegWrite0/1      in   1       lane0/lane1 write enable
// - mem_read_data0/1 in   DATA_W  lane0/lane1 load data
// - alu_result0/1    in   DATA_W  lane0/lane1 ALU result
// - write_reg0/1     in   ADDR_W  lane0/lane1 destination register
// - rd_addr0..3      in   ADDR_W  read-port addresses (ID stage, 2 per issue lane)
// - rd_data0..3      out  DATA_W  read-port data, combinational
// - wb_data0/1       out  DATA_W  selected write-back value per lane, combinational (EX forwarding)
// - wb_en0/1         out  1       effective write enable per lane: RegWrite & write_reg!=0 & !reset
// - retire_count     out  32      registered count of committed register writes
// BEHAVIOUR
// - Reset values: all registers = 0; retire_count = 0. While reset is high: no register writes,
//   wb_en0/1 = 0, rd_data0..3 = 0. wb_data0/1 still reflect inputs.
// - wb_dataN = MemToRegN ? mem_read_dataN : alu_resultN.
// - Write: on posedge, if wb_enN then reg[write_regN] <= wb_dataN. Lane0 is older, lane1 younger.
// - Same-destination conflict (both wb_en, equal write_reg): lane1 value is stored; lane0 is dropped.
// - Register 0: never written; reads of address 0 return 0 irrespective of bypass or write inputs.
// - Read, BYPASS=1: rd_dataK = (wb_en1 && rd_addrK==write_reg1) ? wb_data1 :
//   (wb_en0 && rd_addrK==write_reg0) ? wb_data0 : reg[rd_addrK]. Zero-cycle read-after-write.
// - Read, BYPASS=0: rd_dataK = reg[rd_addrK]. New value is visible the cycle after the write edge.
// - retire_count: += (wb_en0 + wb_en1) per cycle. Count is 0, 1 or 2; a conflict-dropped lane0
//   write still counts. Wraps modulo 2**32 with no saturation.
// - Reset mid-stream: writes presented in the reset cycle are lost. The first cycle after reset
//   deasserts behaves normally.
// - No backpressure: every enabled write commits in the cycle it is presented; latency 1 clk
//   to storage, 0 clk to bypassed reads.
// STRUCTURE
// - Shared package: REG_ZERO = 0; DATA_W/ADDR_W defaults shared with the pipeline-register and
//   forwarding blocks.
// - One sub-module: wb_lane_sel. Per-lane data mux plus effective enable (wb_data, wb_en).
//   Instantiated twice.
// - Storage array, conflict priority, bypass compare (4 ports x 2 lanes), and counter stay in top.
// TESTING
// - Reset, then read all 32 addrs on 4 ports -> all rd_data = 0, retire_count = 0.
// - Lane0 RegWrite=1, MemToReg=0, alu=0x0000_1234, wr=5; rd_addr0=5 same cycle -> rd_data0 =
//   0x1234 (BYPASS=1); next cycle stored 0x1234; retire_count = 1.
// - Both lanes write reg 7: lane0 0xAAAA_AAAA, lane1 0x5555_5555 -> rd same cycle = 0x5555_5555;
//   stored 0x5555_5555; retire_count += 2.
// - Lane1 MemToReg=1, mem=0xDEAD_BEEF, wr=0 -> wb_en1 = 0; rd_addr=0 returns 0; count unchanged.
// - Assert reset while both lanes write regs 3 and 4 -> no writes, rd_data0..3 = 0, count = 0.
//   Deassert reset, then write reg 3 = 0x1 -> stored normally.
// - Preload retire_count near wrap (0xFFFF_FFFF via 2**32-1 writes, or force in sim), then one
//   write -> retire_count = 0x0000_0000.

Source files
------------

// File: rtl/wb_regfile_dual_pkg.sv
// Shared constants for the dual-issue write-back / register-file slice.
// Data/address width defaults are common to the MEM/WB, forwarding and regfile blocks.
// REG_ZERO is the hard-wired zero register index.
package wb_regfile_dual_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;
  localparam int NUM_RD     = 4;

endpackage

// File: rtl/wb_regfile_dual_wb_lane_sel.sv
// Per-lane write-back select: picks load data or ALU result and qualifies the write enable.
// Ports: reset, mem_to_reg, reg_write, mem_read_data, alu_result, write_reg -> wb_data, wb_en.
// Purely combinational, 0 clk latency, no backpressure.
module wb_lane_sel
  import wb_regfile_dual_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              reset,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en
);

  assign wb_data = mem_to_reg ? mem_read_data : alu_result;

  // Writes to the zero register are discarded here so storage, bypass and the
  // retire counter all see the same qualified enable.
  assign wb_en = reg_write && (write_reg != ADDR_W'(REG_ZERO)) && !reset;

endmodule

// File: rtl/wb_regfile_dual.sv
// Write-back stage + architectural register file: 2 write lanes, 4 read ports, retire counter.
// Ports: lane inputs (MemToReg/RegWrite/mem_read_data/alu_result/write_reg x2), rd_addr0..3 ->
// rd_data0..3 (comb, optional same-cycle bypass), wb_data/wb_en x2 (comb), retire_count (reg).
// Latency 1 clk to storage, 0 clk to bypassed reads; no backpressure, every write commits.
module wb_regfile_dual
  import wb_regfile_dual_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemToReg0,
  input  logic              MemToReg1,
  input  logic              RegWrite0,
  input  logic              RegWrite1,
  input  logic [DATA_W-1:0] mem_read_data0,
  input  logic [DATA_W-1:0] mem_read_data1,
  input  logic [DATA_W-1:0] alu_result0,
  input  logic [DATA_W-1:0] alu_result1,
  input  logic [ADDR_W-1:0] write_reg0,
  input  logic [ADDR_W-1:0] write_reg1,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic [DATA_W-1:0] wb_data0,
  output logic [DATA_W-1:0] wb_data1,
  output logic              wb_en0,
  output logic              wb_en1,
  output logic [31:0]       retire_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs    [NREGS];
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_val  [NUM_RD];

  wb_lane_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane0 (
    .reset         (reset),
    .mem_to_reg    (MemToReg0),
    .reg_write     (RegWrite0),
    .mem_read_data (mem_read_data0),
    .alu_result    (alu_result0),
    .write_reg     (write_reg0),
    .wb_data       (wb_data0),
    .wb_en         (wb_en0)
  );

  wb_lane_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane1 (
    .reset         (reset),
    .mem_to_reg    (MemToReg1),
    .reg_write     (RegWrite1),
    .mem_read_data (mem_read_data1),
    .alu_result    (alu_result1),
    .write_reg     (write_reg1),
    .wb_data       (wb_data1),
    .wb_en         (wb_en1)
  );

  // Lane1 is the younger instruction: its assignment is issued last, so on a
  // same-destination conflict its value is the one that lands in storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      retire_count <= '0;
    end else begin
      if (wb_en0) regs[write_reg0] <= wb_data0;
      if (wb_en1) regs[write_reg1] <= wb_data1;
      // A conflict-dropped lane0 write still retires, so both enables count.
      retire_count <= retire_count + 32'(wb_en0) + 32'(wb_en1);
    end
  end

  assign rd_addr[0] = rd_addr0;
  assign rd_addr[1] = rd_addr1;
  assign rd_addr[2] = rd_addr2;
  assign rd_addr[3] = rd_addr3;

  // Bypass checks lane1 first so a read sees the same value storage will hold
  // after the edge. Address 0 and reset force zero regardless of bypass.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_val[k] = regs[rd_addr[k]];
      if (BYPASS != 0) begin
        if (wb_en1 && (rd_addr[k] == write_reg1)) begin
          rd_val[k] = wb_data1;
        end else if (wb_en0 && (rd_addr[k] == write_reg0)) begin
          rd_val[k] = wb_data0;
        end
      end
      if (reset || (rd_addr[k] == ADDR_W'(REG_ZERO))) begin
        rd_val[k] = '0;
      end
    end
  end

  assign rd_data0 = rd_val[0];
  assign rd_data1 = rd_val[1];
  assign rd_data2 = rd_val[2];
  assign rd_data3 = rd_val[3];

endmodule

// File: tb/tb_wb_regfile_dual.sv
// Self-checking bench for wb_regfile_dual (default parameters, BYPASS=1).
// Ports: drives all DUT inputs, observes all outputs against an array-based reference model.
// Inputs change 1ns after posedge, outputs sampled 3ns after posedge.
module tb_wb_regfile_dual;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemToReg0, MemToReg1, RegWrite0, RegWrite1;
  logic [31:0] mem_read_data0, mem_read_data1, alu_result0, alu_result1;
  logic [4:0]  write_reg0, write_reg1;
  logic [4:0]  rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [31:0] rd_data0, rd_data1, rd_data2, rd_data3;
  logic [31:0] wb_data0, wb_data1;
  logic        wb_en0, wb_en1;
  logic [31:0] retire_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  wb_regfile_dual dut (
    .clk(clk), .reset(reset),
    .MemToReg0(MemToReg0), .MemToReg1(MemToReg1),
    .RegWrite0(RegWrite0), .RegWrite1(RegWrite1),
    .mem_read_data0(mem_read_data0), .mem_read_data1(mem_read_data1),
    .alu_result0(alu_result0), .alu_result1(alu_result1),
    .write_reg0(write_reg0), .write_reg1(write_reg1),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .wb_en0(wb_en0), .wb_en1(wb_en1),
    .retire_count(retire_count)
  );

  // ---------------- reference model (architectural rules) ----------------
  function automatic logic [31:0] m_sel(input logic m2r, input logic [31:0] mem, input logic [31:0] alu);
    return m2r ? mem : alu;
  endfunction

  function automatic logic m_en0();
    return RegWrite0 && (write_reg0 != 5'd0) && !reset;
  endfunction

  function automatic logic m_en1();
    return RegWrite1 && (write_reg1 != 5'd0) && !reset;
  endfunction

  // Value an ID-stage read must observe right now: the newest pending write
  // to that register wins, otherwise the architectural value.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (reset || a == 5'd0) return 32'h0;
    if (m_en1() && a == write_reg1) return m_sel(MemToReg1, mem_read_data1, alu_result1);
    if (m_en0() && a == write_reg0) return m_sel(MemToReg0, mem_read_data0, alu_result0);
    return m_regs[a];
  endfunction

  task automatic commit_model();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 32'h0;
    end else begin
      if (m_en0()) m_regs[write_reg0] = m_sel(MemToReg0, mem_read_data0, alu_result0);
      if (m_en1()) m_regs[write_reg1] = m_sel(MemToReg1, mem_read_data1, alu_result1);
      m_cnt = m_cnt + 32'(m_en0()) + 32'(m_en1());
    end
  endtask

  task automatic idle_inputs();
    RegWrite0 = 1'b0; RegWrite1 = 1'b0; MemToReg0 = 1'b0; MemToReg1 = 1'b0;
    mem_read_data0 = 32'h0; mem_read_data1 = 32'h0; alu_result0 = 32'h0; alu_result1 = 32'h0;
    write_reg0 = 5'd0; write_reg1 = 5'd0;
  endtask

  // Commit model state and advance to 1ns after the next posedge.
  task automatic tick();
    commit_model();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    RegWrite0 = 1'b1; write_reg0 = 5'd9; alu_result0 = 32'hFFFF_0000;
    rd_addr0 = 5'd9; rd_addr1 = 5'd1; rd_addr2 = 5'd2; rd_addr3 = 5'd3;
    #2;
    n_tests++;
    if (wb_en0 !== 1'b0 || rd_data0 !== 32'h0) begin
      n_fail++; $display("FAIL reset_hold: wb_en0=%0b rd_data0=%h required 0/0", wb_en0, rd_data0);
    end
    tick(); tick();
    reset = 1'b0;
    idle_inputs();
    for (int a = 0; a < 32; a += 4) begin
      rd_addr0 = 5'(a); rd_addr1 = 5'(a + 1); rd_addr2 = 5'(a + 2); rd_addr3 = 5'(a + 3);
      #2;
      n_tests++;
      if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || rd_data3 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read a=%0d: %h %h %h %h required all 0", a, rd_data0, rd_data1, rd_data2, rd_data3);
      end
      #1;
    end
    n_tests++;
    if (retire_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_count: got %h required 0", retire_count);
    end
  endtask

  task automatic test_bypass_write();
    idle_inputs();
    RegWrite0 = 1'b1; MemToReg0 = 1'b0; alu_result0 = 32'h0000_1234; mem_read_data0 = 32'h7777_7777;
    write_reg0 = 5'd5; rd_addr0 = 5'd5;
    #2;
    n_tests++;
    if (rd_data0 !== 32'h0000_1234 || wb_data0 !== 32'h0000_1234 || wb_en0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_l0: rd=%h wb=%h en=%b required 00001234/00001234/1", rd_data0, wb_data0, wb_en0);
    end
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (rd_data0 !== 32'h0000_1234 || retire_count !== 32'd1) begin
      n_fail++; $display("FAIL stored_l0: rd=%h cnt=%0d required 00001234/1", rd_data0, retire_count);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] c0;
    c0 = m_cnt;
    idle_inputs();
    RegWrite0 = 1'b1; alu_result0 = 32'hAAAA_AAAA; write_reg0 = 5'd7;
    RegWrite1 = 1'b1; alu_result1 = 32'h5555_5555; write_reg1 = 5'd7;
    rd_addr1 = 5'd7;
    #2;
    n_tests++;
    if (rd_data1 !== 32'h5555_5555) begin
      n_fail++; $display("FAIL conflict_bypass: got %h required 55555555", rd_data1);
    end
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (rd_data1 !== 32'h5555_5555 || retire_count !== c0 + 32'd2) begin
      n_fail++;
      $display("FAIL conflict_store: rd=%h cnt=%0d required 55555555/%0d", rd_data1, retire_count, c0 + 32'd2);
    end
  endtask

  task automatic test_reg0();
    logic [31:0] c0;
    c0 = m_cnt;
    idle_inputs();
    RegWrite1 = 1'b1; MemToReg1 = 1'b1; mem_read_data1 = 32'hDEAD_BEEF; write_reg1 = 5'd0;
    rd_addr2 = 5'd0;
    #2;
    n_tests++;
    if (wb_en1 !== 1'b0 || rd_data2 !== 32'h0 || wb_data1 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL reg0_write: en1=%b rd=%h wb=%h required 0/0/deadbeef", wb_en1, rd_data2, wb_data1);
    end
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (rd_data2 !== 32'h0 || retire_count !== c0) begin
      n_fail++; $display("FAIL reg0_after: rd=%h cnt=%0d required 0/%0d", rd_data2, retire_count, c0);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    RegWrite0 = 1'b1; alu_result0 = 32'h0000_0033; write_reg0 = 5'd3;
    RegWrite1 = 1'b1; alu_result1 = 32'h0000_0044; write_reg1 = 5'd4;
    tick();
    reset = 1'b1;
    alu_result0 = 32'h1111_1111; alu_result1 = 32'h2222_2222;
    rd_addr0 = 5'd3; rd_addr1 = 5'd4; rd_addr2 = 5'd5; rd_addr3 = 5'd7;
    #2;
    n_tests++;
    if (wb_en0 !== 1'b0 || wb_en1 !== 1'b0 || wb_data0 !== 32'h1111_1111 || wb_data1 !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL reset_mid_lane: en=%b%b wb0=%h wb1=%h required 00/11111111/22222222",
               wb_en0, wb_en1, wb_data0, wb_data1);
    end
    n_tests++;
    if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || rd_data3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_read: %h %h %h %h required all 0", rd_data0, rd_data1, rd_data2, rd_data3);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    #2;
    n_tests++;
    if (retire_count !== 32'h0 || rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_after: cnt=%0d r3=%h r4=%h required 0/0/0", retire_count, rd_data0, rd_data1);
    end
    RegWrite0 = 1'b1; alu_result0 = 32'h1; write_reg0 = 5'd3;
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (rd_data0 !== 32'h1 || retire_count !== 32'd1) begin
      n_fail++; $display("FAIL reset_mid_resume: r3=%h cnt=%0d required 1/1", rd_data0, retire_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] e0, e1, e2, e3;
    for (int cyc = 0; cyc < 300; cyc++) begin
      reset          = ($urandom_range(0, 40) == 0);
      RegWrite0      = 1'($urandom);
      RegWrite1      = 1'($urandom);
      MemToReg0      = 1'($urandom);
      MemToReg1      = 1'($urandom);
      mem_read_data0 = $urandom;
      mem_read_data1 = $urandom;
      alu_result0    = $urandom;
      alu_result1    = $urandom;
      // Narrow address range so conflicts and bypass hits are frequent.
      write_reg0     = 5'($urandom_range(0, 7));
      write_reg1     = 5'($urandom_range(0, 7));
      rd_addr0       = 5'($urandom_range(0, 7));
      rd_addr1       = 5'($urandom_range(0, 7));
      rd_addr2       = 5'($urandom_range(0, 31));
      rd_addr3       = 5'($urandom_range(0, 31));
      #2;
      e0 = m_read(rd_addr0); e1 = m_read(rd_addr1); e2 = m_read(rd_addr2); e3 = m_read(rd_addr3);
      n_tests++;
      if (rd_data0 !== e0 || rd_data1 !== e1 || rd_data2 !== e2 || rd_data3 !== e3) begin
        n_fail++;
        $display("FAIL rand_read c=%0d: got %h %h %h %h required %h %h %h %h",
                 cyc, rd_data0, rd_data1, rd_data2, rd_data3, e0, e1, e2, e3);
      end
      n_tests++;
      if (wb_en0 !== m_en0() || wb_en1 !== m_en1() ||
          wb_data0 !== m_sel(MemToReg0, mem_read_data0, alu_result0) ||
          wb_data1 !== m_sel(MemToReg1, mem_read_data1, alu_result1)) begin
        n_fail++;
        $display("FAIL rand_lane c=%0d: en=%b%b wb0=%h wb1=%h required %b%b %h %h", cyc, wb_en0, wb_en1,
                 wb_data0, wb_data1, m_en0(), m_en1(),
                 m_sel(MemToReg0, mem_read_data0, alu_result0), m_sel(MemToReg1, mem_read_data1, alu_result1));
      end
      tick();
      #1;
      n_tests++;
      if (retire_count !== m_cnt) begin
        n_fail++; $display("FAIL rand_count c=%0d: got %0d required %0d", cyc, retire_count, m_cnt);
      end
    end
    reset = 1'b0;
    idle_inputs();
    #1;
    for (int a = 0; a < 32; a += 4) begin
      rd_addr0 = 5'(a); rd_addr1 = 5'(a + 1); rd_addr2 = 5'(a + 2); rd_addr3 = 5'(a + 3);
      #1;
      n_tests++;
      if (rd_data0 !== m_regs[a] || rd_data1 !== m_regs[a + 1] ||
          rd_data2 !== m_regs[a + 2] || rd_data3 !== m_regs[a + 3]) begin
        n_fail++;
        $display("FAIL rand_final a=%0d: got %h %h %h %h required %h %h %h %h", a, rd_data0, rd_data1,
                 rd_data2, rd_data3, m_regs[a], m_regs[a + 1], m_regs[a + 2], m_regs[a + 3]);
      end
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    force dut.retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count;
    m_cnt = 32'hFFFF_FFFF;
    RegWrite1 = 1'b1; alu_result1 = 32'h0BAD_F00D; write_reg1 = 5'd12; rd_addr3 = 5'd12;
    #1;
    n_tests++;
    if (retire_count !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_preload: got %h required ffffffff", retire_count);
    end
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (retire_count !== 32'h0 || rd_data3 !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL wrap: cnt=%h r12=%h required 00000000/0badf00d", retire_count, rd_data3);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    rd_addr0 = 5'd0; rd_addr1 = 5'd0; rd_addr2 = 5'd0; rd_addr3 = 5'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_bypass_write();
    test_conflict();
    test_reg0();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
